// File: rtl/ghpc_and_chain_pipe_if.sv
// Operand/result bundle for the masked AND chain: both operand shares, fresh randomness, result shares.
// Latency is set by the attached pipe, not by this bundle.
// No backpressure: there is no ready signal, and the consumer must accept every cycle.
interface ghpc_and_chain_pipe_if #(
  parameter int CHAIN = 3
);
  logic             in_valid;
  logic [CHAIN-1:0] x_s0;
  logic [CHAIN-1:0] x_s1;
  logic [CHAIN-2:0] r;
  logic             out_valid;
  logic             y_s0;
  logic             y_s1;

  modport master (
    output in_valid, x_s0, x_s1, r,
    input  out_valid, y_s0, y_s1
  );

  modport slave (
    input  in_valid, x_s0, x_s1, r,
    output out_valid, y_s0, y_s1
  );
endinterface

// File: rtl/ghpc_and_chain_pipe.sv
// Masked 2-share AND chain y = &x built from CHAIN-1 cascaded GHPC AND gadgets.
// Latency (CHAIN-1)*S cycles, where S=2 (OUT_REG=0) or S=3 (OUT_REG=1).
// No backpressure: the pipe is fully pipelined, takes one issue per cycle and never stalls.
module ghpc_and_chain_pipe #(
  parameter int CHAIN   = 3,
  parameter int OUT_REG = 0
) (
  input logic                  clk,
  input logic                  rst,
  ghpc_and_chain_pipe_if.slave bus
);
  localparam int G = CHAIN - 1;
  localparam int S = (OUT_REG != 0) ? 3 : 2;
  localparam int L = G * S;

  // Chain of a-operand shares: index j feeds gadget j, and index j+1 is the output of gadget j.
  logic [G:0] a_s0;
  logic [G:0] a_s1;

  assign a_s0[0]  = bus.x_s0[0];
  assign a_s1[0]  = bus.x_s1[0];
  assign bus.y_s0 = a_s0[G];
  assign bus.y_s1 = a_s1[G];

  logic [L-1:0] vld_sr;

  // Valid tracking: in_valid delayed by the full chain latency; issues made during reset are dropped.
  always_ff @(posedge clk) begin
    if (rst) vld_sr <= '0;
    else     vld_sr <= {vld_sr[L-2:0], bus.in_valid};
  end

  assign bus.out_valid = vld_sr[L-1];

  for (genvar j = 0; j < G; j++) begin : g_gadget
    localparam int D = j * S;

    logic       a0, a1, b_s0, b_s1, q;
    logic [3:0] p_q;
    logic       a1_q, b1_q;
    logic [3:0] qt_q;
    logic [S-1:0] r_dly;

    assign a0 = a_s0[j];
    assign a1 = a_s1[j];
    assign q  = bus.r[j];

    if (D == 0) begin : g_nodly
      assign b_s0 = bus.x_s0[j+1];
      assign b_s1 = bus.x_s1[j+1];
    end else begin : g_dly
      logic [D-1:0] d_s0;
      logic [D-1:0] d_s1;

      // Hold both shares of operand j+1 back so that they meet the a operand arriving from gadget j-1.
      always_ff @(posedge clk) begin
        if (rst) begin
          d_s0 <= '0;
          d_s1 <= '0;
        end else begin
          d_s0 <= {d_s0[D-2:0], bus.x_s0[j+1]};
          d_s1 <= {d_s1[D-2:0], bus.x_s1[j+1]};
        end
      end

      assign b_s0 = d_s0[D-1];
      assign b_s1 = d_s1[D-1];
    end

    // Step 1: form all four share-0 minterms, each masked by q, and register share 1 beside them.
    always_ff @(posedge clk) begin
      if (rst) begin
        p_q  <= '0;
        a1_q <= 1'b0;
        b1_q <= 1'b0;
      end else begin
        p_q[0] <= ( a0 &  b_s0) ^ q;
        p_q[1] <= (~a0 &  b_s0) ^ q;
        p_q[2] <= ( a0 & ~b_s0) ^ q;
        p_q[3] <= (~a0 & ~b_s0) ^ q;
        a1_q   <= a1;
        b1_q   <= b_s1;
      end
    end

    // Step 2: share 1 selects exactly one masked minterm, and each term is registered before the XOR.
    always_ff @(posedge clk) begin
      if (rst) begin
        qt_q <= '0;
      end else begin
        qt_q[0] <= p_q[0] & ~a1_q & ~b1_q;
        qt_q[1] <= p_q[1] &  a1_q & ~b1_q;
        qt_q[2] <= p_q[2] & ~a1_q &  b1_q;
        qt_q[3] <= p_q[3] &  a1_q &  b1_q;
      end
    end

    // Output share 0 is the mask itself, delayed so that it lines up with share 1.
    always_ff @(posedge clk) begin
      if (rst) r_dly <= '0;
      else     r_dly <= {r_dly[S-2:0], q};
    end

    assign a_s0[j+1] = r_dly[S-1];

    if (OUT_REG != 0) begin : g_oreg
      logic o_q;

      // An extra register on share 1 breaks the XOR path into the next gadget.
      always_ff @(posedge clk) begin
        if (rst) o_q <= 1'b0;
        else     o_q <= ^qt_q;
      end

      assign a_s1[j+1] = o_q;
    end else begin : g_ocomb
      assign a_s1[j+1] = ^qt_q;
    end
  end
endmodule
